cell_display_sequencer: RTL and testbench

//  Scheduler between the CNN result datapath and the 7-segment driver. Accepts one

---
 rtl/cell_display_sequencer.sv | 143 ++++++++++++++
 tb/tb_cell_display_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cell_display_sequencer.sv
// cell_display_sequencer: buffers one eight-cell CNN result frame and walks the
// 7-segment display through its cells, advancing on a dwell timer or on a
// debounced-by-edge user step button.
// Build option: define SEQ_LOOP_EN to wrap from cell 7 back to cell 0 forever
// (frames accepted at any time) instead of stopping and holding on cell 7.
module cell_display_sequencer #(
    parameter int DWELL_CYCLES = 67108864,
    parameter int CNT_W        = 27
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        resValid_i,
    output logic        resReady_o,
    input  logic [63:0] resData_i,
    input  logic        stepBtn_i,
    output logic [7:0]  selValue_o,
    output logic [2:0]  selIdx_o,
    output logic        showEn_o,
    output logic        seqDone_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [63:0]       buf_q, buf_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        selValue_q, selValue_d;
    logic              showEn_q, showEn_d;
    logic              seqDone_q, seqDone_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  dwell_q, dwell_d;
    logic [1:0]        stepSync_q;
    logic              stepPrev_q;

    logic              stepPulse;
    logic              accept;
    logic              expire;

    assign stepPulse = stepSync_q[1] & ~stepPrev_q;
    assign accept    = resValid_i & ready_q;
    assign expire    = (dwell_q == DwellLast);

    // Bring the raw button into the clock domain and remember its last level
    // so a press yields exactly one step pulse however long it is held.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stepSync_q <= 2'b00;
            stepPrev_q <= 1'b0;
        end else begin
            stepSync_q <= {stepSync_q[0], stepBtn_i};
            stepPrev_q <= stepSync_q[1];
        end
    end

    // Next-state logic: dwell timing, cell advance, frame capture and ready.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        dwell_d    = dwell_q;
        showEn_d   = showEn_q;
        seqDone_d  = 1'b0;
        selValue_d = buf_q[{idx_q, 3'b000} +: 8];

        case (state_q)
            SHOW: begin
                if (stepPulse || expire) begin
                    dwell_d = '0;
                    if (idx_q == 3'd7) begin
                        seqDone_d = 1'b1;
`ifdef SEQ_LOOP_EN
                        idx_d = 3'd0;
`else
                        state_d = HOLD;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    dwell_d = dwell_q + CNT_W'(1);
                end
            end
            IDLE, HOLD: begin
                dwell_d = '0;
            end
            default: begin
                state_d = IDLE;
                dwell_d = '0;
            end
        endcase

        if (accept) begin
            buf_d     = resData_i;
            idx_d     = 3'd0;
            dwell_d   = '0;
            showEn_d  = 1'b1;
            seqDone_d = 1'b0;
            state_d   = SHOW;
        end

`ifdef SEQ_LOOP_EN
        ready_d = 1'b1;
`else
        ready_d = (state_d != SHOW);
`endif
    end

    // State and datapath registers; everything clears on reset, frame included.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= 3'd0;
            selValue_q <= 8'd0;
            showEn_q   <= 1'b0;
            seqDone_q  <= 1'b0;
            ready_q    <= 1'b0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            idx_q      <= idx_d;
            selValue_q <= selValue_d;
            showEn_q   <= showEn_d;
            seqDone_q  <= seqDone_d;
            ready_q    <= ready_d;
            dwell_q    <= dwell_d;
        end
    end

    assign resReady_o = ready_q;
    assign selValue_o = selValue_q;
    assign selIdx_o   = idx_q;
    assign showEn_o   = showEn_q;
    assign seqDone_o  = seqDone_q;

endmodule

// File: tb/tb_cell_display_sequencer.sv
// Testbench for cell_display_sequencer with a short dwell time. Expected
// display values come from a small cycle model pushed into a scoreboard queue
// when each frame is offered, and are popped as the display updates.
module tb_cell_display_sequencer;

    localparam int DWELL = 4;
    localparam int CW    = 3;
`ifdef SEQ_LOOP_EN
    localparam bit LoopMode = 1'b1;
`else
    localparam bit LoopMode = 1'b0;
`endif

    logic        clk;
    logic        rstN;
    logic        resValid;
    logic        resReady;
    logic [63:0] resData;
    logic        stepBtn;
    logic [7:0]  selValue;
    logic [2:0]  selIdx;
    logic        showEn;
    logic        seqDone;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          doneCount   = 0;
    logic [7:0]  expQ[$];

    cell_display_sequencer #(
        .DWELL_CYCLES(DWELL),
        .CNT_W       (CW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rstN),
        .resValid_i (resValid),
        .resReady_o (resReady),
        .resData_i  (resData),
        .stepBtn_i  (stepBtn),
        .selValue_o (selValue),
        .selIdx_o   (selIdx),
        .showEn_o   (showEn),
        .seqDone_o  (seqDone)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count completion pulses shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        if (seqDone === 1'b1) doneCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Cycle model of the display: value shown after edge k is the cell
    // selected after edge k-1; stepEdge is the edge on which a step pulse lands.
    task automatic pushExpected(input logic [63:0] frame, input int nEdges,
                                input int stepEdge);
        int idx   = 0;
        int dwell = 0;
        bit held  = 1'b0;
        for (int k = 1; k <= nEdges; k++) begin
            expQ.push_back(frame[idx*8 +: 8]);
            if (!held) begin
                if (k == stepEdge || dwell == DWELL - 1) begin
                    dwell = 0;
                    if (idx == 7) begin
                        if (LoopMode) idx = 0;
                        else held = 1'b1;
                    end else begin
                        idx++;
                    end
                end else begin
                    dwell++;
                end
            end
        end
    endtask

    // Offer a frame for one edge and confirm it was taken.
    task automatic applyStimulus(input logic [63:0] frame);
        @(negedge clk);
        resValid = 1'b1;
        resData  = frame;
        @(posedge clk);
        @(negedge clk);
        resValid = 1'b0;
        checkOutput("ready_after_accept", resReady, LoopMode);
        checkOutput("show_en_after_accept", showEn, 1'b1);
        checkOutput("idx_after_accept", selIdx, 3'd0);
    endtask

    // Step the clock, popping and comparing the displayed value each cycle;
    // optionally press the button or offer a competing frame mid-run.
    task automatic runAndCheck(input int nEdges, input int btnOnK, input int btnOffK,
                               input int validOnK, input int validOffK,
                               input logic [63:0] altFrame);
        logic [7:0] exp;
        for (int k = 1; k <= nEdges; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $error("[TB] FAIL queue_underrun: observed empty expected entry at step %0d", k);
            end else begin
                exp = expQ.pop_front();
                checkOutput("sel_value", selValue, exp);
            end
            if (resValid) checkOutput("ready_in_show", resReady, 1'b0);
            if (k == btnOnK)    stepBtn = 1'b1;
            if (k == btnOffK)   stepBtn = 1'b0;
            if (k == validOnK) begin
                resValid = 1'b1;
                resData  = altFrame;
            end
            if (k == validOffK) resValid = 1'b0;
        end
    endtask

    initial begin
        rstN     = 1'b0;
        resValid = 1'b0;
        resData  = '0;
        stepBtn  = 1'b0;

        // Reset state, then ready rises one clock after release.
        @(negedge clk);
        checkOutput("rst_ready", resReady, 1'b0);
        checkOutput("rst_sel_value", selValue, 8'h00);
        checkOutput("rst_idx", selIdx, 3'd0);
        checkOutput("rst_show_en", showEn, 1'b0);
        checkOutput("rst_seq_done", seqDone, 1'b0);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_release", resReady, 1'b1);

`ifdef SEQ_LOOP_EN
        // Wrapping display: three full passes, one done pulse per wrap.
        pushExpected(64'h0807060504030201, 100, 0);
        applyStimulus(64'h0807060504030201);
        runAndCheck(100, 0, 0, 0, 0, 64'h0);
        checkOutput("loop_done_count", doneCount, 3);
        checkOutput("loop_show_en", showEn, 1'b1);
        checkOutput("loop_ready", resReady, 1'b1);
`else
        // Button presses while idle do nothing.
        repeat (2) begin
            @(negedge clk); stepBtn = 1'b1;
            repeat (3) @(negedge clk);
            stepBtn = 1'b0;
            repeat (3) @(negedge clk);
        end
        checkOutput("idle_step_idx", selIdx, 3'd0);
        checkOutput("idle_step_show_en", showEn, 1'b0);
        checkOutput("idle_step_done", doneCount, 0);

        // Full auto-advance pass with a competing frame held off mid-show.
        pushExpected(64'h0807060504030201, 32, 0);
        applyStimulus(64'h0807060504030201);
        runAndCheck(32, 0, 0, 5, 20, 64'hF0E0D0C0B0A09080);
        checkOutput("done_pulse", seqDone, 1'b1);
        checkOutput("done_count_a", doneCount, 1);
        checkOutput("idx_at_end", selIdx, 3'd7);
        @(negedge clk);
        checkOutput("done_pulse_width", seqDone, 1'b0);
        repeat (100) @(negedge clk);
        checkOutput("hold_idx", selIdx, 3'd7);
        checkOutput("hold_value", selValue, 8'h08);
        checkOutput("hold_show_en", showEn, 1'b1);
        checkOutput("hold_ready", resReady, 1'b1);
        checkOutput("hold_done_count", doneCount, 1);

        // Button presses while holding do nothing.
        repeat (3) begin
            @(negedge clk); stepBtn = 1'b1;
            repeat (4) @(negedge clk);
            stepBtn = 1'b0;
            repeat (4) @(negedge clk);
        end
        checkOutput("hold_step_idx", selIdx, 3'd7);
        checkOutput("hold_step_value", selValue, 8'h08);
        checkOutput("hold_step_done", doneCount, 1);

        // Frame accepted from HOLD; long press at idx 2 advances exactly once.
        pushExpected(64'h8877665544332211, 30, 10);
        applyStimulus(64'h8877665544332211);
        runAndCheck(30, 7, 27, 0, 0, 64'h0);
        checkOutput("done_count_c", doneCount, 2);
        checkOutput("idx_end_c", selIdx, 3'd7);

        // Step pulse landing on the same edge as dwell expiry advances once.
        pushExpected(64'h1F1E1D1C1B1A1918, 12, 4);
        applyStimulus(64'h1F1E1D1C1B1A1918);
        runAndCheck(12, 1, 5, 0, 0, 64'h0);
        checkOutput("idx_after_coincide", selIdx, 3'd3);

        // Reset in the middle of a show clears everything at once.
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("midrst_sel_value", selValue, 8'h00);
        checkOutput("midrst_idx", selIdx, 3'd0);
        checkOutput("midrst_show_en", showEn, 1'b0);
        checkOutput("midrst_ready", resReady, 1'b0);
        checkOutput("midrst_seq_done", seqDone, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready_after", resReady, 1'b1);
        checkOutput("midrst_idx_after", selIdx, 3'd0);
        checkOutput("midrst_show_en_after", showEn, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
